// File: rtl/video_timing_pkg.sv
// Shared constants for the raster timing generator: standard mode timings
// and the bit positions of hsync/vsync inside the TMDS control-data pair.
package video_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
    bit          pol;
  } axis_timing_t;

  localparam axis_timing_t MODE_640X480_H  = '{active: 640,  fp: 16,  sync: 96,  bp: 48,  pol: 1'b0};
  localparam axis_timing_t MODE_640X480_V  = '{active: 480,  fp: 10,  sync: 2,   bp: 33,  pol: 1'b0};
  localparam axis_timing_t MODE_800X600_H  = '{active: 800,  fp: 40,  sync: 128, bp: 88,  pol: 1'b1};
  localparam axis_timing_t MODE_800X600_V  = '{active: 600,  fp: 1,   sync: 4,   bp: 23,  pol: 1'b1};
  localparam axis_timing_t MODE_1280X720_H = '{active: 1280, fp: 110, sync: 40,  bp: 220, pol: 1'b1};
  localparam axis_timing_t MODE_1280X720_V = '{active: 720,  fp: 5,   sync: 5,   bp: 20,  pol: 1'b1};

  localparam int CD_HSYNC = 0;
  localparam int CD_VSYNC = 1;

endpackage

// File: rtl/vt_delay_pipe.sv
// Width x depth register chain with a per-bit reset value; depth 0 is a
// plain wire so callers need not special-case zero extra latency.
module vt_delay_pipe #(
  parameter int             W       = 1,
  parameter int             DEPTH   = 0,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused;
    assign unused = &{1'b0, clk, rst_n};
    assign q      = d;
  end else begin : g_chain
    logic [W-1:0] stage [DEPTH];

    // NOTE: this array is a register chain, not a RAM, so every element is
    // reset; an asynchronous reset must empty the whole pipeline at once.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: h/v counters, one registered decode
// stage, then OUT_DELAY aligned delay stages feeding the TMDS path.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int OUT_DELAY = 0,
  parameter int XW        = 12,
  parameter int YW        = 11
) (
  input  logic          pixclk,
  input  logic          rst_n,
  input  logic          en,
  output logic          VDE,
  output logic [1:0]    CD,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          frame_start,
  output logic          line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  if (OUT_DELAY < 0 || OUT_DELAY > 4 ||
      H_ACTIVE <= 0 || V_ACTIVE <= 0 || H_SYNC <= 0 || V_SYNC <= 0 ||
      64'(H_ACTIVE) > (64'd1 << XW) || 64'(V_ACTIVE) > (64'd1 << YW)) begin : g_bad_params
    $fatal(1, "video_timing_gen: illegal parameter set");
  end

  // One bit wider than the counters so a sync window ending exactly at the
  // total (zero back porch, power-of-two total) still compares correctly.
  localparam logic [HW:0] H_ACT      = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0] H_HS_START = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0] H_HS_END   = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0] V_ACT      = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0] V_VS_START = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0] V_VS_END   = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

  typedef struct packed {
    logic          vde;
    logic [1:0]    cd;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          frame_start;
    logic          line_start;
  } out_t;

  localparam out_t RST_OUT = '{
    vde: 1'b0, cd: {~VS_POL, ~HS_POL}, x: '0, y: '0,
    frame_start: 1'b0, line_start: 1'b0
  };

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [HW:0]   h_ext;
  logic [VW:0]   v_ext;
  logic          active;
  logic          hs;
  logic          vs;
  out_t          dec;
  out_t          dec_q;
  out_t          out;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign h_ext  = {1'b0, h_cnt};
  assign v_ext  = {1'b0, v_cnt};
  assign active = (h_ext < H_ACT) && (v_ext < V_ACT);
  assign hs     = (h_ext >= H_HS_START) && (h_ext < H_HS_END);
  assign vs     = (v_ext >= V_VS_START) && (v_ext < V_VS_END);

  // NOTE: the idle word is assigned first so no path through this block
  // leaves a field unassigned, which would otherwise infer a latch.
  always_comb begin
    dec = RST_OUT;
    if (en) begin
      dec.vde           = active;
      dec.cd[CD_HSYNC]  = hs ? HS_POL : ~HS_POL;
      dec.cd[CD_VSYNC]  = vs ? VS_POL : ~VS_POL;
      dec.x             = active ? XW'(h_cnt) : '0;
      dec.y             = active ? YW'(v_cnt) : '0;
      dec.frame_start   = (h_cnt == '0) && (v_cnt == '0);
      dec.line_start    = (h_cnt == '0) && (v_ext < V_ACT);
    end
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) dec_q <= RST_OUT;
    else        dec_q <= dec;
  end

  vt_delay_pipe #(
    .W       ($bits(out_t)),
    .DEPTH   (OUT_DELAY),
    .RST_VAL (RST_OUT)
  ) u_delay (
    .clk   (pixclk),
    .rst_n (rst_n),
    .d     (dec_q),
    .q     (out)
  );

  assign VDE         = out.vde;
  assign CD          = out.cd;
  assign x           = out.x;
  assign y           = out.y;
  assign frame_start = out.frame_start;
  assign line_start  = out.line_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: four generator instances (VGA, small mode at delay 0
// and 3, zero-front-porch mode at delay 2) checked every cycle they run.
module tb_video_timing_gen;

  typedef enum int {M_VGA, M_SMALL, M_FP0} mode_e;

  typedef struct {
    int          due;
    logic [27:0] val;
  } item_t;

  logic        pixclk;
  logic [3:0]  rst_n_v;
  logic [3:0]  en_v;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  item_t       sb [4][$];
  logic [27:0] act [4];
  int          dly [4]     = '{0, 0, 3, 2};
  mode_e       mode_of [4] = '{M_VGA, M_SMALL, M_SMALL, M_FP0};
  string       dut_name [4] = '{"vga_d0", "small_d0", "small_d3", "fp0_d2"};

  logic vga_vde, s0_vde, s3_vde, fp_vde;
  logic [1:0] vga_cd, s0_cd, s3_cd, fp_cd;
  logic [11:0] vga_x, s0_x, s3_x;
  logic [10:0] vga_y, s0_y, s3_y;
  logic [1:0]  fp_x;
  logic [0:0]  fp_y;
  logic vga_fs, s0_fs, s3_fs, fp_fs;
  logic vga_ls, s0_ls, s3_ls, fp_ls;

  video_timing_gen u_vga (
    .pixclk(pixclk), .rst_n(rst_n_v[0]), .en(en_v[0]), .VDE(vga_vde), .CD(vga_cd),
    .x(vga_x), .y(vga_y), .frame_start(vga_fs), .line_start(vga_ls)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .OUT_DELAY(0)
  ) u_small0 (
    .pixclk(pixclk), .rst_n(rst_n_v[1]), .en(en_v[1]), .VDE(s0_vde), .CD(s0_cd),
    .x(s0_x), .y(s0_y), .frame_start(s0_fs), .line_start(s0_ls)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .OUT_DELAY(3)
  ) u_small3 (
    .pixclk(pixclk), .rst_n(rst_n_v[2]), .en(en_v[2]), .VDE(s3_vde), .CD(s3_cd),
    .x(s3_x), .y(s3_y), .frame_start(s3_fs), .line_start(s3_ls)
  );

  video_timing_gen #(
    .H_ACTIVE(3), .H_FP(0), .H_SYNC(1), .H_BP(2),
    .V_ACTIVE(2), .V_FP(0), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .OUT_DELAY(2), .XW(2), .YW(1)
  ) u_fp0 (
    .pixclk(pixclk), .rst_n(rst_n_v[3]), .en(en_v[3]), .VDE(fp_vde), .CD(fp_cd),
    .x(fp_x), .y(fp_y), .frame_start(fp_fs), .line_start(fp_ls)
  );

  assign act[0] = {vga_vde, vga_cd, vga_x, vga_y, vga_fs, vga_ls};
  assign act[1] = {s0_vde, s0_cd, s0_x, s0_y, s0_fs, s0_ls};
  assign act[2] = {s3_vde, s3_cd, s3_x, s3_y, s3_fs, s3_ls};
  assign act[3] = {fp_vde, fp_cd, {10'b0, fp_x}, {10'b0, fp_y}, fp_fs, fp_ls};

  initial begin
    pixclk = 1'b0;
    forever #5 pixclk = ~pixclk;
  end

  always @(posedge pixclk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [27:0] got, input logic [27:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got vde/cd/x/y/fs/ls=%h, expected %h", name, cyc, got, exp);
    end
  endtask

  // Expected outputs for raster position n (cycles since the first enabled
  // edge), written from the stated geometry of each test mode.
  function automatic logic [27:0] model(input mode_e m, input int n);
    int ht, vt, ha, va, hs0, hs1, vs0, vs1, h, v;
    bit pol, vde, hs, vs;
    case (m)
      M_VGA:   begin ht = 800; vt = 525; ha = 640; va = 480; hs0 = 656; hs1 = 752; vs0 = 490; vs1 = 492; pol = 1'b0; end
      M_SMALL: begin ht = 7;   vt = 6;   ha = 4;   va = 3;   hs0 = 5;   hs1 = 6;   vs0 = 4;   vs1 = 5;   pol = 1'b1; end
      default: begin ht = 6;   vt = 4;   ha = 3;   va = 2;   hs0 = 3;   hs1 = 4;   vs0 = 2;   vs1 = 3;   pol = 1'b0; end
    endcase
    h   = n % ht;
    v   = (n / ht) % vt;
    vde = (h < ha) && (v < va);
    hs  = (h >= hs0) && (h < hs1);
    vs  = (v >= vs0) && (v < vs1);
    return {vde, vs ? pol : ~pol, hs ? pol : ~pol,
            12'(vde ? h : 0), 11'(vde ? v : 0),
            (h == 0) && (v == 0), (h == 0) && (v < va)};
  endfunction

  function automatic logic [27:0] idle_val(input mode_e m);
    return (m == M_SMALL) ? 28'h0 : {1'b0, 2'b11, 25'b0};
  endfunction

  task automatic push_run(input int d, input int k0, input int cnt);
    for (int n = 0; n < cnt; n++) sb[d].push_back('{due: k0 + n + dly[d], val: model(mode_of[d], n)});
  endtask

  task automatic push_idle(input int d, input int due, input int cnt);
    for (int i = 0; i < cnt; i++) sb[d].push_back('{due: due + i, val: idle_val(mode_of[d])});
  endtask

  // First enabled edge k0 from an idle pipeline: idle words fill the delay.
  task automatic start_run(input int d, input int k0, input int cnt);
    push_idle(d, k0, dly[d]);
    push_run(d, k0, cnt);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge pixclk);
    #1;
  endtask

  function automatic int pending();
    return sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size();
  endfunction

  always @(negedge pixclk) begin : monitor
    item_t it;
    for (int d = 0; d < 4; d++) begin
      while (sb[d].size() > 0 && sb[d][0].due <= cyc) begin
        it = sb[d].pop_front();
        check(dut_name[d], act[d], it.val);
      end
    end
  end

  initial begin : stimulus
    int k0;
    rst_n_v = '0;
    en_v    = '0;

    wait_cyc(2);
    for (int d = 0; d < 4; d++) push_idle(d, cyc, 1);
    wait_cyc(1);
    rst_n_v  = '1;
    en_v[0]  = 1'b1;

    // VGA: run to (h=100, v=7), disable for 10 edges, restart one line.
    k0 = cyc + 1;
    push_run(0, k0, 5700);
    wait_cyc(5700);
    en_v[0] = 1'b0;
    push_idle(0, k0 + 5700, 10);
    wait_cyc(10);
    en_v[0] = 1'b1;
    push_run(0, cyc + 1, 900);
    wait_cyc(905);
    en_v[0] = 1'b0;

    // Small mode at delay 0 and 3: two frames plus, then a 4-edge en drop.
    en_v[2:1] = 2'b11;
    k0 = cyc + 1;
    start_run(1, k0, 101);
    start_run(2, k0, 101);
    wait_cyc(101);
    en_v[2:1] = 2'b00;
    push_idle(1, k0 + 101 + dly[1], 4);
    push_idle(2, k0 + 101 + dly[2], 4);
    wait_cyc(4);
    en_v[2:1] = 2'b11;
    push_run(1, cyc + 1, 50);
    push_run(2, cyc + 1, 50);
    wait_cyc(60);
    en_v[2:1] = 2'b00;

    // Zero front porch, delay 2: async reset pulse mid active line (h=1, v=1).
    en_v[3] = 1'b1;
    k0 = cyc + 1;
    start_run(3, k0, 31);
    wait_cyc(34);
    #1;
    rst_n_v[3] = 1'b0;
    push_idle(3, cyc, 1);
    #5;
    rst_n_v[3] = 1'b1;
    start_run(3, cyc + 1, 30);
    wait_cyc(40);

    for (int i = 0; i < 200 && pending() > 0; i++) @(posedge pixclk);
    check("scoreboard_drain", 28'(pending()), 28'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised raster timing generator for the HDMI/DVI output path. It replaces the fixed-mode timing block. It produces VDE and CD (hsync/vsync control data) for the TMDS encoders, plus pixel coordinates and frame/line strobes for the pixel source (e.g. the Tetris renderer). Resolution, porches, sync polarity and output pipeline delay are all parameters. A runtime enable restarts the raster cleanly.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active low)
VS_POL, 0, vsync active level (0 = active low)
OUT_DELAY, 0, extra register stages on all outputs, range 0..4
XW, 12, width of x output
YW, 11, width of y output

Ports:
pixclk  in  1  pixel clock; the single clock
rst_n  in  1  asynchronous active-low reset
en  in  1  raster run enable
VDE  out  1  video data enable (active region)
CD  out  2  control data to TMDS encoders: CD[0]=hsync, CD[1]=vsync, at configured polarity
x  out  XW  active-pixel column, 0..H_ACTIVE-1; 0 when VDE=0
y  out  YW  active-pixel row, 0..V_ACTIVE-1; 0 when VDE=0
frame_start  out  1  one-cycle pulse at the first pixel of a frame
line_start  out  1  one-cycle pulse at the first pixel of each active line

Behaviour:
- Clock/reset: one clock, pixclk. Reset is asynchronous and active-low on rst_n.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Internal counter widths are clog2 of each total.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0.
- v_cnt increments when h_cnt wraps, counts 0..V_TOTAL-1, and wraps to 0 on the same cycle as the h wrap at v_cnt = V_TOTAL-1.
- Counters advance only while en=1.
- Decode from the counter state (h_cnt, v_cnt):
  - active = (h<H_ACTIVE) && (v<V_ACTIVE)
  - hs = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for the whole line
  - frame_start = (h==0 && v==0)
  - line_start = (h==0 && v<V_ACTIVE)
- Output polarity: CD[0] = hs ? HS_POL : ~HS_POL. CD[1] = vs ? VS_POL : ~VS_POL.
- Latency: every output is registered once after decode, then passes through OUT_DELAY further stages. Total latency from counter state to output is 1+OUT_DELAY cycles, and all outputs stay mutually aligned.
- Reset values of every output and every pipeline stage:
  - VDE=0, x=0, y=0, frame_start=0, line_start=0
  - CD={~VS_POL,~HS_POL} (inactive sync)
  - h_cnt=0, v_cnt=0
- en=0 (synchronous): h_cnt and v_cnt are cleared to 0, and the decode stage forces the reset values. The pipeline keeps shifting, so the outputs reach inactive values 1+OUT_DELAY cycles later.
- en rising: the first enabled cycle has counter state (0,0). frame_start is emitted 1+OUT_DELAY cycles later.
- en deasserted mid-line or mid-frame aborts the frame. No partial-frame completion.
- rst_n asserted mid-frame clears everything immediately, including the pipeline. Counting resumes from (0,0) on the first edge after release, if en=1.
- Boundaries:
  - H_SYNC or V_SYNC of 1 gives a single-cycle or single-line sync.
  - H_FP=0 is legal: hsync starts immediately after the last active pixel.
  - x and y must never exceed H_ACTIVE-1 and V_ACTIVE-1.
- Elaboration check: OUT_DELAY outside 0..4, any *_ACTIVE or *_SYNC equal to 0, or XW/YW too narrow for the active size → fatal error.

Decomposition:
- Package video_timing_pkg holds:
  - mode constant sets for 640x480@60, 800x600@60 and 1280x720@60 (active/FP/SYNC/BP/polarity)
  - CD bit-index constants CD_HSYNC=0 and CD_VSYNC=1
- One sub-module, vt_delay_pipe: a parametrised width×depth register chain with async active-low reset and a per-bit reset value. It implements the OUT_DELAY stages; depth 0 means pass-through.

Test Plan:
1. Reset, then default parameters with en=1. First VDE=1 at cycle 1 after release with x=0, y=0, frame_start=1. VDE stays high 640 cycles. CD[0] goes low at h=656 for exactly 96 cycles and idles high.
2. Run 2 full frames. frame_start period is 420000 cycles (800×525). line_start appears 480 times per frame. CD[1] is low for 1600 cycles beginning at line 490.
3. Small mode: H 4/1/1/1, V 3/1/1/1, HS_POL=VS_POL=1. Check every cycle of 2 frames against a reference model: hsync high at h=5, vsync high on line 4, x/y sequence 0..3 by 0..2.
4. OUT_DELAY=3, same stimulus as test 3. Every output equals the OUT_DELAY=0 result shifted by exactly 3 cycles.
5. Drop en at (h=100, v=7) for 10 cycles, then reassert. Outputs go to inactive 1+OUT_DELAY cycles after the drop. frame_start fires 1+OUT_DELAY cycles after re-enable with x=0, y=0.
6. Pulse rst_n low asynchronously mid-active-line with OUT_DELAY=2. All outputs go to their reset values immediately, without waiting for a clock edge. The raster restarts at (0,0).
